// File: rtl/pwm_pkg.sv
// Types and defaults shared by the PWM generator and its duty controller.
package pwm_pkg;

    localparam int DUTY_W = 4;
    localparam int DUTY_MAX_DEF = 10;
    localparam int DUTY_DEFAULT_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        DONE
    } ramp_state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] d,
        input logic [DUTY_W-1:0] lim
    );
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Board-side buttons/ramp controls and generator-side duty commands.
interface pwm_duty_ctrl_if;
    import pwm_pkg::*;

    logic              btn_up;
    logic              btn_down;
    logic              ramp_start;
    logic [DUTY_W-1:0] ramp_target;
    logic              inc_duty;
    logic              dec_duty;
    logic              pwm_rst;
    logic [DUTY_W-1:0] duty;
    logic              busy;
    logic              ramp_done;

    modport master (
        output btn_up, btn_down, ramp_start, ramp_target,
        input  inc_duty, dec_duty, pwm_rst, duty, busy, ramp_done
    );

    modport slave (
        input  btn_up, btn_down, ramp_start, ramp_target,
        output inc_duty, dec_duty, pwm_rst, duty, busy, ramp_done
    );

endinterface

// File: rtl/pwm_debounce.sv
// Two-flop synchronizer, stable-sample debouncer and rising-edge strobe.
module pwm_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2, level;
    logic [CW-1:0] cnt;
    logic          accept;

    // Strobe fires on the same edge the level flips, keeping latency 2+N.
    assign accept = (s2 != level) && (cnt == LAST);
    assign rise   = accept && s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-command sequencer for the PWM generator; optional soft-start ramp
// compiled in with PWM_DUTY_CTRL_RAMP_EN.
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter int PERIOD          = 10,
    parameter int DUTY_MAX        = DUTY_MAX_DEF,
    parameter int DUTY_DEFAULT    = DUTY_DEFAULT_DEF,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RAMP_PERIODS    = 2
) (
    input logic           clk,
    input logic           reset,
    pwm_duty_ctrl_if.slave bus
);

    localparam int PW = $clog2(PERIOD);
    localparam logic [PW-1:0] PLAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PPRE  = PW'(PERIOD - 2);
    localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DDEF = DUTY_W'(DUTY_DEFAULT);

    logic [PW-1:0]     pcnt;
    logic              pre_bnd;
    logic              up_rise, dn_rise;
    logic              up_pend, dn_pend, up_pend_n, dn_pend_n;
    logic              man_inc, man_dec, step_inc, step_dec;
    logic              inc_q, dec_q, rst_q, busy_q, done_q;
    logic [DUTY_W-1:0] duty_q, duty_n;

    pwm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_up),
        .rise  (up_rise)
    );

    pwm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_down),
        .rise  (dn_rise)
    );

    // Commands are decided one cycle early so the registered pulse
    // lands exactly on the boundary cycle.
    assign pre_bnd = (pcnt == PPRE);

    always_comb begin
        up_pend_n = up_pend | up_rise;
        dn_pend_n = dn_pend | dn_rise;
        man_inc   = 1'b0;
        man_dec   = 1'b0;
        if (pre_bnd) begin
            up_pend_n = up_rise;
            dn_pend_n = dn_rise;
            unique case (1'b1)
                up_pend && !dn_pend: man_inc = (duty_q < DMAX);
                dn_pend && !up_pend: man_dec = (duty_q != '0);
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (1'b1)
            inc_q:   duty_n = duty_q + DUTY_W'(1);
            dec_q:   duty_n = duty_q - DUTY_W'(1);
            default: duty_n = duty_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt    <= '0;
            up_pend <= 1'b0;
            dn_pend <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            duty_q  <= DDEF;
            rst_q   <= 1'b1;
        end else begin
            pcnt    <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
            up_pend <= up_pend_n;
            dn_pend <= dn_pend_n;
            inc_q   <= man_inc | step_inc;
            dec_q   <= man_dec | step_dec;
            duty_q  <= duty_n;
            rst_q   <= 1'b0;
        end
    end

`ifdef PWM_DUTY_CTRL_RAMP_EN
    localparam int SW = $clog2(RAMP_PERIODS + 1);
    localparam logic [SW-1:0] SLAST = SW'(RAMP_PERIODS - 1);

    ramp_state_t       state, state_n;
    logic [DUTY_W-1:0] tgt, tgt_n, tgt_in;
    logic [SW-1:0]     scnt, scnt_n;
    logic              manual;

    assign tgt_in = clamp_duty(bus.ramp_target, DMAX);
    assign manual = up_pend | dn_pend;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            tgt    <= '0;
            scnt   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            tgt    <= tgt_n;
            scnt   <= scnt_n;
            busy_q <= (state_n == RAMP);
            done_q <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n  = state;
        tgt_n    = tgt;
        scnt_n   = scnt;
        step_inc = 1'b0;
        step_dec = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ramp_start) begin
                    tgt_n   = tgt_in;
                    scnt_n  = '0;
                    state_n = (tgt_in == duty_n) ? DONE : RAMP;
                end
            end
            RAMP: begin
                if (pre_bnd && manual) begin
                    state_n = IDLE;
                end else if (bus.ramp_start) begin
                    tgt_n  = tgt_in;
                    scnt_n = '0;
                end else if (pre_bnd) begin
                    if (scnt != SLAST) begin
                        scnt_n = scnt + SW'(1);
                    end else begin
                        scnt_n = '0;
                        unique case (1'b1)
                            tgt > duty_q: step_inc = 1'b1;
                            tgt < duty_q: step_dec = 1'b1;
                            default:      state_n  = DONE;
                        endcase
                    end
                end else if ((inc_q || dec_q) && duty_n == tgt) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
`else
    logic unused_ramp;

    assign unused_ramp = ^{bus.ramp_start, bus.ramp_target};
    assign step_inc    = 1'b0;
    assign step_dec    = 1'b0;
    assign busy_q      = 1'b0;
    assign done_q      = 1'b0;
`endif

    assign bus.inc_duty  = inc_q;
    assign bus.dec_duty  = dec_q;
    assign bus.pwm_rst   = rst_q;
    assign bus.duty      = duty_q;
    assign bus.busy      = busy_q;
    assign bus.ramp_done = done_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl: manual vectors plus ramp/reset sequences.
module tb_pwm_duty_ctrl;
    import pwm_pkg::*;

    typedef struct {
        string name;
        int    start;
        int    kind;
        int    hold;
        int    presses;
        int    exp_inc;
        int    exp_dec;
        int    exp_duty;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   inc_cnt = 0;
    int   dec_cnt = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    int   tb_pcnt = 0;
    vec_t vecs[8];

    pwm_duty_ctrl_if bus();

    pwm_duty_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        tb_pcnt <= !reset ? 0 : (tb_pcnt == 9 ? 0 : tb_pcnt + 1);

    always @(negedge clk) begin
        if (reset) begin
            if (bus.inc_duty) begin
                inc_cnt++;
                checks++;
                if (tb_pcnt != 9) begin
                    errors++;
                    $display("FAIL inc_phase pcnt=%0d required=9", tb_pcnt);
                end
            end
            if (bus.dec_duty) begin
                dec_cnt++;
                checks++;
                if (tb_pcnt != 9) begin
                    errors++;
                    $display("FAIL dec_phase pcnt=%0d required=9", tb_pcnt);
                end
            end
            if (bus.ramp_done) done_cnt++;
            if (bus.busy) busy_cyc++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        inc_cnt  = 0;
        dec_cnt  = 0;
        done_cnt = 0;
        busy_cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // kind: 0 up, 1 down, 2 both
    task automatic press(input int kind, input int hold);
        @(negedge clk);
        bus.btn_up   = (kind != 1);
        bus.btn_down = (kind != 0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic ramp(input int t);
        @(negedge clk);
        bus.ramp_start  = 1'b1;
        bus.ramp_target = 4'(t);
        @(negedge clk);
        bus.ramp_start  = 1'b0;
    endtask

    initial begin
        bus.btn_up      = 1'b0;
        bus.btn_down    = 1'b0;
        bus.ramp_start  = 1'b0;
        bus.ramp_target = '0;

        vecs[0] = '{"up_one",    5, 0, 8, 1, 1, 0, 6};
        vecs[1] = '{"up_glitch", 5, 0, 3, 1, 0, 0, 5};
        vecs[2] = '{"up_min",    5, 0, 4, 1, 1, 0, 6};
        vecs[3] = '{"up_sat",    8, 0, 8, 5, 2, 0, 10};
        vecs[4] = '{"dn_sat",    2, 1, 8, 5, 0, 2, 0};
        vecs[5] = '{"dn_one",    5, 1, 8, 1, 0, 1, 4};
        vecs[6] = '{"dn_glitch", 5, 1, 3, 1, 0, 0, 5};
        vecs[7] = '{"both",      5, 2, 8, 1, 0, 0, 5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_duty", int'(bus.duty), 5);
        chk("rst_pwm_rst", int'(bus.pwm_rst), 1);
        chk("rst_inc", int'(bus.inc_duty), 0);
        chk("rst_dec", int'(bus.dec_duty), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.ramp_done), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("pwm_rst_hold", int'(bus.pwm_rst), 1);
        @(negedge clk);
        chk("pwm_rst_drop", int'(bus.pwm_rst), 0);

        foreach (vecs[i]) begin
            do_reset();
            for (int k = 0; k < vecs[i].start - 5; k++) press(0, 8);
            for (int k = 0; k < 5 - vecs[i].start; k++) press(1, 8);
            clr();
            for (int k = 0; k < vecs[i].presses; k++)
                press(vecs[i].kind, vecs[i].hold);
            chk($sformatf("%s_inc", vecs[i].name), inc_cnt, vecs[i].exp_inc);
            chk($sformatf("%s_dec", vecs[i].name), dec_cnt, vecs[i].exp_dec);
            chk($sformatf("%s_duty", vecs[i].name), int'(bus.duty),
                vecs[i].exp_duty);
        end

        // Button held across a reset that interrupts its debounce.
        do_reset();
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (3) @(posedge clk);
        clr();
        do_reset();
        chk("held_rst_cmd", inc_cnt + dec_cnt, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_inc", inc_cnt, 1);
        chk("held_duty", int'(bus.duty), 6);

`ifdef PWM_DUTY_CTRL_RAMP_EN
        do_reset();
        clr();
        ramp(9);
        chk("r9_busy_start", int'(bus.busy), 1);
        for (int k = 0; k < 150 && done_cnt == 0; k++) @(posedge clk);
        repeat (3) @(negedge clk);
        chk("r9_done", done_cnt, 1);
        chk("r9_inc", inc_cnt, 4);
        chk("r9_duty", int'(bus.duty), 9);
        chk("r9_busy_cyc", busy_cyc, 78);
        chk("r9_busy_end", int'(bus.busy), 0);

        do_reset();
        clr();
        ramp(15);
        for (int k = 0; k < 200 && done_cnt == 0; k++) @(posedge clk);
        repeat (3) @(negedge clk);
        chk("r15_done", done_cnt, 1);
        chk("r15_inc", inc_cnt, 5);
        chk("r15_duty", int'(bus.duty), 10);
        chk("r15_busy_cyc", busy_cyc, 98);

        do_reset();
        clr();
        ramp(15);
        for (int k = 0; k < 100 && inc_cnt == 0; k++) @(posedge clk);
        press(1, 8);
        chk("abort_inc", inc_cnt, 1);
        chk("abort_dec", dec_cnt, 1);
        chk("abort_done", done_cnt, 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_duty", int'(bus.duty), 5);
`else
        do_reset();
        clr();
        ramp(9);
        repeat (60) @(negedge clk);
        chk("noramp_busy", busy_cyc, 0);
        chk("noramp_done", done_cnt, 0);
        chk("noramp_inc", inc_cnt, 0);
        chk("noramp_duty", int'(bus.duty), 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
